// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: Depth-entry circular buffer with valid/ready on both sides,
// synchronous flush, and a registered occupancy output for hazard logic.
//
// state   | meaning
// EMPTY   | count_q == 0, valid_o low
// PARTIAL | 0 < count_q < Depth, both sides may transfer
// FULL    | count_q == Depth, accepts only as pass-through when enabled
module pipe_stage_elastic #(
  parameter int DataWidth        = 64,
  parameter int Depth            = 2,
  parameter bit AllowPassThrough = 1'b1,
  parameter bit ClearDataOnReset = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [DataWidth-1:0]         data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [DataWidth-1:0]         data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] mem_d [Depth];
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 full, empty, push, pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  always_comb begin
    ready_o = ~flush_i & ~reset_i & (~full | (AllowPassThrough & ready_i & full));
    valid_o = ~empty & ~flush_i;
    data_o  = mem_q[rd_ptr_q];
    count_o = count_q;
    push    = valid_i & ready_o;
    pop     = valid_o & ready_i;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage reset is optional so wide payloads can map onto reset-free flops.
  if (ClearDataOnReset) begin : g_mem_rst
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        mem_q <= '{default: '0};
      end else begin
        mem_q <= mem_d;
      end
    end
  end else begin : g_mem_norst
    always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: five configurations driven side by side and
// compared each cycle against a queue-based reference model.
module tb_pipe_stage_elastic;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din  [N];
  logic [7:0] dout [N];
  logic       vin  [N];
  logic       rin  [N];
  logic       fin  [N];
  logic       vout [N];
  logic       rout [N];
  logic [1:0] c0, c1;
  logic       c2, c3;
  logic [2:0] c4;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mq [N][$];

  always #5 clk = ~clk;

  // inst 0: Depth 2 pass-through; 1: Depth 3; 2: Depth 1 pass-through; 3: Depth 1 no pass-through; 4: Depth 4
  pipe_stage_elastic #(.DataWidth(8), .Depth(2), .AllowPassThrough(1'b1)) u_d2 (
    .clk_i(clk), .reset_i(rst), .flush_i(fin[0]), .data_i(din[0]), .valid_i(vin[0]),
    .ready_o(rout[0]), .data_o(dout[0]), .valid_o(vout[0]), .ready_i(rin[0]), .count_o(c0));
  pipe_stage_elastic #(.DataWidth(8), .Depth(3), .AllowPassThrough(1'b1)) u_d3 (
    .clk_i(clk), .reset_i(rst), .flush_i(fin[1]), .data_i(din[1]), .valid_i(vin[1]),
    .ready_o(rout[1]), .data_o(dout[1]), .valid_o(vout[1]), .ready_i(rin[1]), .count_o(c1));
  pipe_stage_elastic #(.DataWidth(8), .Depth(1), .AllowPassThrough(1'b1)) u_d1_pt (
    .clk_i(clk), .reset_i(rst), .flush_i(fin[2]), .data_i(din[2]), .valid_i(vin[2]),
    .ready_o(rout[2]), .data_o(dout[2]), .valid_o(vout[2]), .ready_i(rin[2]), .count_o(c2));
  pipe_stage_elastic #(.DataWidth(8), .Depth(1), .AllowPassThrough(1'b0)) u_d1_npt (
    .clk_i(clk), .reset_i(rst), .flush_i(fin[3]), .data_i(din[3]), .valid_i(vin[3]),
    .ready_o(rout[3]), .data_o(dout[3]), .valid_o(vout[3]), .ready_i(rin[3]), .count_o(c3));
  pipe_stage_elastic #(.DataWidth(8), .Depth(4), .AllowPassThrough(1'b1)) u_d4 (
    .clk_i(clk), .reset_i(rst), .flush_i(fin[4]), .data_i(din[4]), .valid_i(vin[4]),
    .ready_o(rout[4]), .data_o(dout[4]), .valid_o(vout[4]), .ready_i(rin[4]), .count_o(c4));

  function automatic int dep_of(int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 1;
      3: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit apt_of(int i);
    return (i != 3);
  endfunction

  function automatic int cnt_of(int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      3: return int'(c3);
      default: return int'(c4);
    endcase
  endfunction

  function automatic logic exp_ready(int i);
    int s;
    s = mq[i].size();
    return !fin[i] && !rst && ((s < dep_of(i)) || (apt_of(i) && rin[i] && s == dep_of(i)));
  endfunction

  function automatic logic exp_valid(int i);
    return (mq[i].size() != 0) && !fin[i];
  endfunction

  function automatic logic [7:0] exp_data(int i);
    return (mq[i].size() != 0) ? mq[i][0] : 8'h00;
  endfunction

  // Reference model: a FIFO queue per instance, updated on the transfer rules.
  always @(posedge clk or posedge rst) begin
    logic pu, po;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        pu = vin[i] && exp_ready(i);
        po = exp_valid(i) && rin[i];
        if (fin[i]) begin
          mq[i].delete();
        end else begin
          if (po) void'(mq[i].pop_front());
          if (pu) mq[i].push_back(din[i]);
        end
      end
    end
  end

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      din[i] = 8'h00;
      vin[i] = 1'b0;
      rin[i] = 1'b0;
      fin[i] = 1'b0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_chk++;
      if (cnt_of(i) > dep_of(i) || cnt_of(i) !== mq[i].size()) begin
        n_fail++;
        $display("FAIL count_inv[%0d]: got %0d, expected %0d (max %0d)", i, cnt_of(i), mq[i].size(), dep_of(i));
      end
    end
  endtask

  task automatic test_reset();
    idle();
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      n_chk++;
      if (vout[i] !== 1'b0 || rout[i] !== 1'b0 || cnt_of(i) !== 0 || dout[i] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got v=%b r=%b c=%0d d=%h, expected v=0 r=0 c=0 d=00",
                 i, vout[i], rout[i], cnt_of(i), dout[i]);
      end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      n_chk++;
      if (rout[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release_ready[%0d]: got %b, expected 1", i, rout[i]);
      end
    end
    cyc();
  endtask

  task automatic test_fill_drain();
    idle();
    vin[0] = 1'b1; din[0] = 8'hA1;
    #1;
    n_chk++;
    if (rout[0] !== 1'b1) begin n_fail++; $display("FAIL fill_ready_empty: got %b, expected 1", rout[0]); end
    cyc();
    n_chk++;
    if (cnt_of(0) !== 1) begin n_fail++; $display("FAIL fill_count1: got %0d, expected 1", cnt_of(0)); end
    din[0] = 8'hA2;
    cyc();
    din[0] = 8'hFF;
    #1;
    n_chk++;
    if (cnt_of(0) !== 2 || rout[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got c=%0d r=%b, expected c=2 r=0", cnt_of(0), rout[0]);
    end
    cyc();
    vin[0] = 1'b0; rin[0] = 1'b1;
    #1;
    n_chk++;
    if (vout[0] !== 1'b1 || dout[0] !== 8'hA1) begin
      n_fail++; $display("FAIL drain_first: got v=%b d=%h, expected v=1 d=a1", vout[0], dout[0]);
    end
    cyc();
    #1;
    n_chk++;
    if (vout[0] !== 1'b1 || dout[0] !== 8'hA2) begin
      n_fail++; $display("FAIL drain_second: got v=%b d=%h, expected v=1 d=a2", vout[0], dout[0]);
    end
    cyc();
    #1;
    n_chk++;
    if (vout[0] !== 1'b0 || cnt_of(0) !== 0) begin
      n_fail++; $display("FAIL drain_empty: got v=%b c=%0d, expected v=0 c=0", vout[0], cnt_of(0));
    end
    idle();
  endtask

  task automatic test_backpressure();
    idle();
    vin[0] = 1'b1; din[0] = 8'hC1;
    cyc();
    din[0] = 8'hC2;
    cyc();
    vin[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_chk++;
      if (vout[0] !== 1'b1 || dout[0] !== 8'hC1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h, expected v=1 d=c1", k, vout[0], dout[0]);
      end
      cyc();
    end
    rin[0] = 1'b1;
    #1;
    n_chk++;
    if (dout[0] !== 8'hC1) begin n_fail++; $display("FAIL bp_release: got %h, expected c1", dout[0]); end
    cyc();
    #1;
    n_chk++;
    if (dout[0] !== 8'hC2 || vout[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: got v=%b d=%h, expected v=1 d=c2", vout[0], dout[0]);
    end
    cyc();
    idle();
  endtask

  task automatic test_wrap();
    logic [7:0] got[$];
    int nxt;
    int n;
    idle();
    nxt = 1;
    n = 0;
    while (n < 200 && got.size() < 10) begin
      vin[1] = (nxt <= 10);
      din[1] = 8'(nxt);
      rin[1] = 1'($urandom_range(0, 1));
      #1;
      n_chk++;
      if (vout[1] !== exp_valid(1) || rout[1] !== exp_ready(1) ||
          (exp_valid(1) && dout[1] !== exp_data(1))) begin
        n_fail++;
        $display("FAIL wrap_cycle: got v=%b r=%b d=%h, expected v=%b r=%b d=%h",
                 vout[1], rout[1], dout[1], exp_valid(1), exp_ready(1), exp_data(1));
      end
      if (vout[1] && rin[1]) got.push_back(dout[1]);
      if (vin[1] && rout[1]) nxt++;
      cyc();
      n++;
    end
    n_chk++;
    if (got.size() != 10) begin
      n_fail++; $display("FAIL wrap_total: got %0d items, expected 10", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      n_chk++;
      if (got[k] !== 8'(k + 1)) begin
        n_fail++; $display("FAIL wrap_order[%0d]: got %h, expected %h", k, got[k], 8'(k + 1));
      end
    end
    idle();
  endtask

  task automatic test_passthrough();
    int p2, p3, pops2, pops3;
    idle();
    p2 = 0; p3 = 0; pops2 = 0; pops3 = 0;
    vin[2] = 1'b1; rin[2] = 1'b1;
    vin[3] = 1'b1; rin[3] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      din[2] = 8'(8'h10 + p2);
      din[3] = 8'(8'h10 + p3);
      #1;
      n_chk++;
      if (rout[2] !== exp_ready(2) || rout[3] !== exp_ready(3)) begin
        n_fail++;
        $display("FAIL pt_ready[%0d]: got %b/%b, expected %b/%b", k, rout[2], rout[3], exp_ready(2), exp_ready(3));
      end
      if (vout[2]) begin
        n_chk++;
        if (dout[2] !== 8'(8'h10 + pops2)) begin
          n_fail++; $display("FAIL pt_data[%0d]: got %h, expected %h", k, dout[2], 8'(8'h10 + pops2));
        end
        pops2++;
      end
      if (vout[3]) begin
        n_chk++;
        if (dout[3] !== 8'(8'h10 + pops3)) begin
          n_fail++; $display("FAIL npt_data[%0d]: got %h, expected %h", k, dout[3], 8'(8'h10 + pops3));
        end
        pops3++;
      end
      if (rout[2]) p2++;
      if (rout[3]) p3++;
      cyc();
    end
    n_chk++;
    if (pops2 != 11 || cnt_of(2) !== 1) begin
      n_fail++; $display("FAIL pt_throughput: got %0d pops c=%0d, expected 11 pops c=1", pops2, cnt_of(2));
    end
    n_chk++;
    if (pops3 != 6) begin
      n_fail++; $display("FAIL npt_throughput: got %0d pops, expected 6", pops3);
    end
    idle();
    rin[2] = 1'b1; rin[3] = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_flush();
    idle();
    vin[4] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[4] = 8'(8'h31 + k);
      cyc();
    end
    n_chk++;
    if (cnt_of(4) !== 3) begin n_fail++; $display("FAIL flush_pre_count: got %0d, expected 3", cnt_of(4)); end
    fin[4] = 1'b1; din[4] = 8'hEE; rin[4] = 1'b1;
    #1;
    n_chk++;
    if (vout[4] !== 1'b0 || rout[4] !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle: got v=%b r=%b, expected v=0 r=0", vout[4], rout[4]);
    end
    cyc();
    fin[4] = 1'b0; vin[4] = 1'b0; rin[4] = 1'b0;
    #1;
    n_chk++;
    if (cnt_of(4) !== 0 || vout[4] !== 1'b0) begin
      n_fail++; $display("FAIL flush_after: got c=%0d v=%b, expected c=0 v=0", cnt_of(4), vout[4]);
    end
    vin[4] = 1'b1; din[4] = 8'h55;
    cyc();
    vin[4] = 1'b0; rin[4] = 1'b1;
    #1;
    n_chk++;
    if (vout[4] !== 1'b1 || dout[4] !== 8'h55) begin
      n_fail++; $display("FAIL flush_next_push: got v=%b d=%h, expected v=1 d=55", vout[4], dout[4]);
    end
    cyc();
    #1;
    n_chk++;
    if (vout[4] !== 1'b0) begin n_fail++; $display("FAIL flush_drained: got v=%b, expected 0", vout[4]); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    vin[0] = 1'b1; din[0] = 8'hB1;
    cyc();
    din[0] = 8'hB2;
    cyc();
    vin[0] = 1'b0;
    #1;
    n_chk++;
    if (cnt_of(0) !== 2) begin n_fail++; $display("FAIL rmid_pre_count: got %0d, expected 2", cnt_of(0)); end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (vout[0] !== 1'b0 || cnt_of(0) !== 0 || dout[0] !== 8'h00 || rout[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: got v=%b c=%0d d=%h r=%b, expected v=0 c=0 d=00 r=0",
               vout[0], cnt_of(0), dout[0], rout[0]);
    end
    cyc();
    rst = 1'b0;
    #1;
    n_chk++;
    if (rout[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b, expected 1", rout[0]); end
    rin[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++;
      if (vout[0] !== 1'b0) begin
        n_fail++; $display("FAIL rmid_stale[%0d]: got v=%b d=%h, expected v=0", k, vout[0], dout[0]);
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_random();
    idle();
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++) begin
        vin[i] = 1'($urandom_range(0, 1));
        rin[i] = 1'($urandom_range(0, 1));
        din[i] = 8'($urandom);
        fin[i] = ($urandom_range(0, 15) == 0);
      end
      #1;
      for (int i = 0; i < N; i++) begin
        n_chk++;
        if (vout[i] !== exp_valid(i) || rout[i] !== exp_ready(i) ||
            (exp_valid(i) && dout[i] !== exp_data(i))) begin
          n_fail++;
          $display("FAIL random[%0d] inst %0d: got v=%b r=%b d=%h, expected v=%b r=%b d=%h",
                   k, i, vout[i], rout[i], dout[i], exp_valid(i), exp_ready(i), exp_data(i));
        end
      end
      cyc();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill_drain();
    test_backpressure();
    test_wrap();
    test_passthrough();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
